match_clear_engine: RTL and testbench



---
 rtl/match_clear_engine.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_match_clear_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_clear_engine.sv
// match_clear_engine: serial board load, then scan/clear/fall cascades
// until stable; one-cycle result pulse carries the accumulated score.
// Ports: clk, rst_n (async, active-low); in_valid/in_color raster load;
//   busy (load through result cycle); out_valid/out_score result strobe.
// Option: define MCE_PASS_COUNT_EN to add out_passes[4:0], the number of
//   scan passes that found at least one match.
module match_clear_engine #(
  parameter int ROWS     = 6,
  parameter int COLS     = 6,
  parameter int CW       = 3,
  parameter int EMPTY    = 7,
  parameter int MIN_RUN  = 3,
  parameter int SW       = 7,
  parameter int MAX_PASS = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_color,
  output logic          busy,
  output logic          out_valid,
  output logic [SW-1:0] out_score
`ifdef MCE_PASS_COUNT_EN
  ,
  output logic [4:0]    out_passes
`endif
);

  localparam int N    = ROWS * COLS;
  localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int KW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int PW   = $clog2(MAX_PASS + 1);
  localparam int HW   = $clog2(ROWS + COLS + 2);

  localparam logic [CW-1:0] EMPTY_C = CW'(EMPTY);
  localparam logic [SW-1:0] SMAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCAN, S_CLEAR, S_FALL, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] board_q [N];
  logic [CW-1:0] board_d [N];
  logic [N-1:0]  mark_q, mark_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] score_q, score_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_score_q, out_score_d;
`ifdef MCE_PASS_COUNT_EN
  logic [4:0]    mpass_q, mpass_d;
  logic [4:0]    out_passes_q, out_passes_d;
`endif

  logic [N-1:0]  scan_mark;
  logic [HW-1:0] scan_hits;
  logic [SW:0]   score_sum;
  logic [CW-1:0] fall_board [N];
  logic          fall_moved;

  // Row k and column k are checked in the same cycle; every
  // equal non-empty window of MIN_RUN cells is one hit.
  always_comb begin
    logic run;
    run       = 1'b0;
    scan_mark = '0;
    scan_hits = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j <= COLS - MIN_RUN; j++) begin
        if (k_q == KW'(r)) begin
          run = (board_q[r*COLS+j] != EMPTY_C);
          for (int t = 1; t < MIN_RUN; t++) begin
            if (board_q[r*COLS+j+t] != board_q[r*COLS+j])
              run = 1'b0;
          end
          if (run) begin
            scan_hits = scan_hits + 1'b1;
            for (int t = 0; t < MIN_RUN; t++)
              scan_mark[r*COLS+j+t] = 1'b1;
          end
        end
      end
    end
    for (int c = 0; c < COLS; c++) begin
      for (int j = 0; j <= ROWS - MIN_RUN; j++) begin
        if (k_q == KW'(c)) begin
          run = (board_q[j*COLS+c] != EMPTY_C);
          for (int t = 1; t < MIN_RUN; t++) begin
            if (board_q[(j+t)*COLS+c] != board_q[j*COLS+c])
              run = 1'b0;
          end
          if (run) begin
            scan_hits = scan_hits + 1'b1;
            for (int t = 0; t < MIN_RUN; t++)
              scan_mark[(j+t)*COLS+c] = 1'b1;
          end
        end
      end
    end
  end

  // One gravity step: per column, the lowest hole with something
  // above it is filled by shifting everything above it down.
  always_comb begin
    logic seen;
    logic found;
    int   tgt;
    seen       = 1'b0;
    found      = 1'b0;
    tgt        = 0;
    fall_moved = 1'b0;
    fall_board = board_q;
    for (int c = 0; c < COLS; c++) begin
      seen  = 1'b0;
      found = 1'b0;
      tgt   = 0;
      for (int r = 0; r < ROWS; r++) begin
        if (board_q[r*COLS+c] == EMPTY_C) begin
          if (seen) begin
            found = 1'b1;
            tgt   = r;
          end
        end else begin
          seen = 1'b1;
        end
      end
      if (found) begin
        fall_moved = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
          if (r == 0)
            fall_board[c] = EMPTY_C;
          else if (r <= tgt)
            fall_board[r*COLS+c] = board_q[(r-1)*COLS+c];
        end
      end
    end
  end

  always_comb begin
    score_sum   = {1'b0, score_q} + (SW+1)'(scan_hits);
    state_d     = state_q;
    board_d     = board_q;
    mark_d      = mark_q;
    idx_d       = idx_q;
    k_d         = k_q;
    score_d     = score_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_score_d = '0;
`ifdef MCE_PASS_COUNT_EN
    mpass_d      = mpass_q;
    out_passes_d = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          board_d[0] = in_color;
          idx_d      = IW'(1);
          mark_d     = '0;
          score_d    = '0;
          pass_d     = '0;
          busy_d     = 1'b1;
          state_d    = S_LOAD;
`ifdef MCE_PASS_COUNT_EN
          mpass_d    = '0;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          board_d[idx_q] = in_color;
          if (idx_q == IW'(N - 1)) begin
            k_d     = '0;
            state_d = S_SCAN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        mark_d  = mark_q | scan_mark;
        score_d = score_sum[SW] ? SMAX : score_sum[SW-1:0];
        if (k_q == KW'(MAXD - 1)) begin
          pass_d = pass_q + 1'b1;
`ifdef MCE_PASS_COUNT_EN
          if (|mark_d)
            mpass_d = mpass_q + 1'b1;
`endif
          if ((|mark_d) && (pass_d < PW'(MAX_PASS))) begin
            state_d = S_CLEAR;
          end else begin
            out_valid_d = 1'b1;
            out_score_d = score_d;
            state_d     = S_DONE;
`ifdef MCE_PASS_COUNT_EN
            out_passes_d = mpass_d;
`endif
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_CLEAR: begin
        for (int i = 0; i < N; i++) begin
          if (mark_q[i])
            board_d[i] = EMPTY_C;
        end
        mark_d  = '0;
        state_d = S_FALL;
      end
      S_FALL: begin
        board_d = fall_board;
        if (!fall_moved) begin
          k_d     = '0;
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Board contents need no reset; kept apart from the reset flops.
  always_ff @(posedge clk) begin
    board_q <= board_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mark_q      <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      score_q     <= '0;
      pass_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_score_q <= '0;
`ifdef MCE_PASS_COUNT_EN
      mpass_q      <= '0;
      out_passes_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mark_q      <= mark_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      score_q     <= score_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_score_q <= out_score_d;
`ifdef MCE_PASS_COUNT_EN
      mpass_q      <= mpass_d;
      out_passes_q <= out_passes_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_score = out_score_q;
`ifdef MCE_PASS_COUNT_EN
  assign out_passes = out_passes_q;
`endif

endmodule

// File: tb/tb_match_clear_engine.sv
// tb_match_clear_engine: directed boards with hand-derived scores
// for match_clear_engine at default parameters.
module tb_match_clear_engine;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_color;
  logic       busy;
  logic       out_valid;
  logic [6:0] out_score;
`ifdef MCE_PASS_COUNT_EN
  logic [4:0] out_passes;
`endif

  match_clear_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_color  (in_color),
    .busy      (busy),
    .out_valid (out_valid),
    .out_score (out_score)
`ifdef MCE_PASS_COUNT_EN
    ,
    .out_passes(out_passes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt;
  int total;

  logic [2:0] brd [36];
  logic       got;
  int         lat;
  logic [6:0] res_score;
  logic [4:0] res_passes;
  logic       res_busy;

  task automatic set_base();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        brd[r*6+c] = 3'((r + 2*c) % 6);
  endtask

  task automatic load_board();
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_color = brd[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_color = 3'd0;
  endtask

  task automatic wait_result(input int maxc);
    got        = 1'b0;
    lat        = 0;
    res_score  = '0;
    res_passes = '0;
    res_busy   = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got       = 1'b1;
        res_score = out_score;
        res_busy  = busy;
`ifdef MCE_PASS_COUNT_EN
        res_passes = out_passes;
`endif
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_color = 3'd0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    else pass_cnt++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid);
    else pass_cnt++;
    total++;
    if (out_score !== 7'd0) $display("FAIL reset_score got=%0d want=0", out_score);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_base();
    set_base();
    load_board();
    total++;
    if (busy !== 1'b1) $display("FAIL base_busy_scan got=%b want=1", busy);
    else pass_cnt++;
    total++;
    if (out_score !== 7'd0) $display("FAIL base_score_idle got=%0d want=0", out_score);
    else pass_cnt++;
    wait_result(200);
    total++;
    if (got !== 1'b1) $display("FAIL base_valid got=%b want=1", got);
    else pass_cnt++;
    total++;
    if (lat != 6) $display("FAIL base_latency got=%0d want=6", lat);
    else pass_cnt++;
    total++;
    if (res_score !== 7'd0) $display("FAIL base_score got=%0d want=0", res_score);
    else pass_cnt++;
    total++;
    if (res_busy !== 1'b1) $display("FAIL base_busy_valid got=%b want=1", res_busy);
    else pass_cnt++;
`ifdef MCE_PASS_COUNT_EN
    total++;
    if (res_passes !== 5'd0) $display("FAIL base_passes got=%0d want=0", res_passes);
    else pass_cnt++;
`endif
    @(negedge clk);
    total++;
    if ({busy, out_valid, out_score} !== 9'd0)
      $display("FAIL base_after got=%b/%b/%0d want=0/0/0", busy, out_valid, out_score);
    else pass_cnt++;
  endtask

  task automatic test_row0_ignore_in();
    set_base();
    for (int c = 0; c < 3; c++) brd[c] = 3'd1;
    load_board();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_color = 3'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_color = 3'd0;
    wait_result(200);
    total++;
    if (got !== 1'b1) $display("FAIL row0_valid got=%b want=1", got);
    else pass_cnt++;
    total++;
    if (res_score !== 7'd1) $display("FAIL row0_score got=%0d want=1", res_score);
    else pass_cnt++;
`ifdef MCE_PASS_COUNT_EN
    total++;
    if (res_passes !== 5'd1) $display("FAIL row0_passes got=%0d want=1", res_passes);
    else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic test_row5_run5();
    set_base();
    for (int c = 0; c < 5; c++) brd[30+c] = 3'd0;
    load_board();
    wait_result(200);
    total++;
    if (got !== 1'b1) $display("FAIL row5_valid got=%b want=1", got);
    else pass_cnt++;
    total++;
    if (res_score !== 7'd3) $display("FAIL row5_score got=%0d want=3", res_score);
    else pass_cnt++;
`ifdef MCE_PASS_COUNT_EN
    total++;
    if (res_passes !== 5'd1) $display("FAIL row5_passes got=%0d want=1", res_passes);
    else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic test_shared_cell();
    set_base();
    for (int r = 0; r < 3; r++) brd[r*6+2] = 3'd1;
    for (int c = 2; c < 5; c++) brd[12+c] = 3'd1;
    load_board();
    wait_result(200);
    // Base cell (3,2) is also 1, so the vertical run is 4 long.
    total++;
    if (got !== 1'b1) $display("FAIL shared_valid got=%b want=1", got);
    else pass_cnt++;
    total++;
    if (res_score !== 7'd3) $display("FAIL shared_score got=%0d want=3", res_score);
    else pass_cnt++;
`ifdef MCE_PASS_COUNT_EN
    total++;
    if (res_passes !== 5'd1) $display("FAIL shared_passes got=%0d want=1", res_passes);
    else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic test_cascade();
    set_base();
    for (int c = 0; c < 3; c++) brd[30+c] = 3'd0;
    brd[34] = 3'd5;
    brd[26] = 3'd5;
    load_board();
    wait_result(300);
    total++;
    if (got !== 1'b1) $display("FAIL cascade_valid got=%b want=1", got);
    else pass_cnt++;
    total++;
    if (res_score !== 7'd2) $display("FAIL cascade_score got=%0d want=2", res_score);
    else pass_cnt++;
`ifdef MCE_PASS_COUNT_EN
    total++;
    if (res_passes !== 5'd2) $display("FAIL cascade_passes got=%0d want=2", res_passes);
    else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic seen;
    set_base();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_color = brd[i];
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL abort_busy_load got=%b want=1", busy);
    else pass_cnt++;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL abort_quiet got=%b want=0", seen);
    else pass_cnt++;
    load_board();
    wait_result(200);
    total++;
    if (got !== 1'b1) $display("FAIL abort_reload_valid got=%b want=1", got);
    else pass_cnt++;
    total++;
    if (res_score !== 7'd0) $display("FAIL abort_reload_score got=%0d want=0", res_score);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_fall();
    logic seen;
    set_base();
    for (int c = 0; c < 5; c++) brd[30+c] = 3'd0;
    load_board();
    repeat (7) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL rstfall_busy_before got=%b want=1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, out_valid, out_score} !== 9'd0)
      $display("FAIL rstfall_outputs got=%b/%b/%0d want=0/0/0", busy, out_valid, out_score);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rstfall_no_valid got=%b want=0", seen);
    else pass_cnt++;
    set_base();
    for (int c = 0; c < 3; c++) brd[c] = 3'd1;
    load_board();
    wait_result(200);
    total++;
    if (got !== 1'b1) $display("FAIL rstfall_reload_valid got=%b want=1", got);
    else pass_cnt++;
    total++;
    if (res_score !== 7'd1) $display("FAIL rstfall_reload_score got=%0d want=1", res_score);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    test_reset();
    test_base();
    test_row0_ignore_in();
    test_row5_run5();
    test_shared_cell();
    test_cascade();
    test_abort();
    test_reset_in_fall();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
